// File: rtl/msx_mouse_reader.sv
// MSX mouse nibble-protocol initiator: toggles strobe, samples four nibbles, assembles X/Y deltas and buttons.
// Optional absent-device detection is compiled in with `define MSX_MOUSE_DETECT_EN.
`timescale 1ns/1ps
module msx_mouse_reader #(
  parameter int SETTLE_CYC   = 1000,
  parameter int POLL_CYC     = 357000,
  parameter int DETECT_POLLS = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] joy_in,
  output logic       strobe,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       present
);

  localparam int PW = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  if (POLL_CYC <= 4 * (SETTLE_CYC + 1) + 4 || SETTLE_CYC < 1 || DETECT_POLLS < 1) begin : g_bad_params
    $error("msx_mouse_reader: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      sync1_q, sync2_q;
  logic [PW-1:0]   poll_cnt_q;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            strobe_q, strobe_d;
  logic [11:0]     nib_q, nib_d;
  logic [7:0]      dx_q, dx_d, dy_q, dy_d;
  logic [1:0]      btn_q, btn_d;
  logic            valid_q, valid_d;
  logic [7:0]      x_raw, y_raw;

  // Two-flop synchroniser; idle lines float high, so reset to all-ones.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= joy_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      poll_cnt_q <= '0;
    end else if (poll_cnt_q == POLL_LAST) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + PW'(1);
    end
  end

  // Nibbles 0..2 shift in as {X[7:4], X[3:0], Y[7:4]}; nibble 3 is taken straight from the synchroniser.
  assign x_raw = nib_q[11:4];
  assign y_raw = {nib_q[3:0], sync2_q[3:0]};

`ifdef MSX_MOUSE_DETECT_EN
  localparam int AW = $clog2(DETECT_POLLS + 1);
  localparam logic [AW-1:0] ABS_MAX = AW'(DETECT_POLLS);
  logic [AW-1:0] absent_cnt_q, absent_cnt_d;
  logic          present_q, present_d;
`endif

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    idx_d        = idx_q;
    strobe_d     = strobe_q;
    nib_d        = nib_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    btn_d        = btn_q;
    valid_d      = 1'b0;
`ifdef MSX_MOUSE_DETECT_EN
    absent_cnt_d = absent_cnt_q;
    present_d    = present_q;
`endif
    case (state_q)
      IDLE: begin
        if (poll_cnt_q == POLL_LAST && enable) begin
          state_d      = SETTLE;
          strobe_d     = ~strobe_q;
          settle_cnt_d = '0;
          idx_d        = 2'd0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      SAMPLE: begin
        if (idx_q != 2'd3) begin
          nib_d        = {nib_q[7:0], sync2_q[3:0]};
          idx_d        = idx_q + 2'd1;
          strobe_d     = ~strobe_q;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          // Results land together with valid so the consumer sees them in the DONE cycle.
          state_d = DONE;
          valid_d = 1'b1;
          dx_d    = x_raw;
          dy_d    = y_raw;
          btn_d   = ~sync2_q[5:4];
`ifdef MSX_MOUSE_DETECT_EN
          if (x_raw == 8'hFF && y_raw == 8'hFF) begin
            if (absent_cnt_q != ABS_MAX) begin
              absent_cnt_d = absent_cnt_q + AW'(1);
            end
            if (absent_cnt_q >= ABS_MAX - AW'(1)) begin
              present_d = 1'b0;
            end
          end else begin
            absent_cnt_d = '0;
            present_d    = 1'b1;
          end
          if (!present_d) begin
            dx_d = 8'h00;
            dy_d = 8'h00;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      idx_q        <= 2'd0;
      strobe_q     <= 1'b0;
      nib_q        <= '0;
      dx_q         <= 8'h00;
      dy_q         <= 8'h00;
      btn_q        <= 2'b00;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      idx_q        <= idx_d;
      strobe_q     <= strobe_d;
      nib_q        <= nib_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      btn_q        <= btn_d;
      valid_q      <= valid_d;
    end
  end

`ifdef MSX_MOUSE_DETECT_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      absent_cnt_q <= '0;
      present_q    <= 1'b1;
    end else begin
      absent_cnt_q <= absent_cnt_d;
      present_q    <= present_d;
    end
  end
  assign present = present_q;
`else
  assign present = 1'b1;
`endif

  assign strobe = strobe_q;
  assign dx     = dx_q;
  assign dy     = dy_q;
  assign btn    = btn_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader: a behavioural mouse responder answers each strobe edge with the next nibble.
`timescale 1ns/1ps
module tb_msx_mouse_reader;
  localparam int SC = 4;
  localparam int PC = 64;
  localparam int DP = 8;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] joy_in;
  logic       strobe;
  logic [7:0] dx, dy;
  logic [1:0] btn;
  logic       valid;
  logic       present;

  always #5 clk_sys = ~clk_sys;

  msx_mouse_reader #(.SETTLE_CYC(SC), .POLL_CYC(PC), .DETECT_POLLS(DP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (enable),
    .joy_in  (joy_in),
    .strobe  (strobe),
    .dx      (dx),
    .dy      (dy),
    .btn     (btn),
    .valid   (valid),
    .present (present)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int vcount  = 0;
  int edge_cnt  = 0;
  int resp_base = 0;
  int t0_last   = 0;
  int t0_prev   = 0;
  logic [7:0] resp_x = 8'hFF;
  logic [7:0] resp_y = 8'hFF;
  logic [1:0] resp_bp = 2'b11;
  logic       glitch_on = 1'b0;
  logic [3:0] resp_nib;

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (valid === 1'b1) vcount <= vcount + 1;
  always @(strobe) edge_cnt = edge_cnt + 1;

  // Responder: the k-th strobe edge of a frame presents nibble k-1; lines idle high otherwise.
  always_comb begin
    case (edge_cnt - resp_base)
      1:       resp_nib = resp_x[7:4];
      2:       resp_nib = resp_x[3:0];
      3:       resp_nib = resp_y[7:4];
      4:       resp_nib = resp_y[3:0];
      default: resp_nib = 4'hF;
    endcase
    joy_in = {resp_bp, (glitch_on ? 4'h5 : resp_nib)};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_t0(output int ok);
    logic pre;
    pre = strobe;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (strobe !== pre) begin
        ok = 1;
        break;
      end
    end
  endtask

  // gmode: 0 none, 1 glitch in cycles T0+1 and T0+3 (must be ignored), 2 glitch in T0+2 (reaches the T0+4 sample).
  task automatic run_frame(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [1:0] bp,
                           input logic [7:0] ex, input logic [7:0] ey, input logic [1:0] eb,
                           input int drop_en, input int gmode);
    logic pre, last;
    int ok;
    logic [31:0] emask, vmask;
    logic [7:0] gdx, gdy;
    logic [1:0] gbtn;
    resp_x = x;
    resp_y = y;
    resp_bp = bp;
    resp_base = edge_cnt;
    pre = strobe;
    wait_t0(ok);
    chk({tag, "_start"}, ok, 1);
    t0_prev = t0_last;
    t0_last = cyc;
    emask = 0;
    vmask = 0;
    gdx = 8'h00;
    gdy = 8'h00;
    gbtn = 2'b00;
    last = strobe;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_sys);
      glitch_on = (gmode == 1 && (k == 1 || k == 3)) || (gmode == 2 && k == 2);
      if (k == drop_en) enable = 1'b0;
      if (strobe !== last) emask[k] = 1'b1;
      last = strobe;
      if (valid === 1'b1) vmask[k] = 1'b1;
      if (k == 20) begin
        gdx = dx;
        gdy = dy;
        gbtn = btn;
      end
    end
    glitch_on = 1'b0;
    chk({tag, "_edges"}, emask, (32'd1 << 5) | (32'd1 << 10) | (32'd1 << 15));
    chk({tag, "_valid"}, vmask, 32'd1 << 20);
    chk({tag, "_dx"}, gdx, ex);
    chk({tag, "_dy"}, gdy, ey);
    chk({tag, "_btn"}, gbtn, eb);
    chk({tag, "_parity"}, strobe, pre);
  endtask

  initial begin
    int ok, e0, v0;
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_strobe", strobe, 0);
    chk("rst_dx", dx, 0);
    chk("rst_dy", dy, 0);
    chk("rst_btn", btn, 0);
    chk("rst_valid", valid, 0);
    chk("rst_present", present, 1);
    reset = 1'b0;

    run_frame("fa", 8'h12, 8'hFE, 2'b10, 8'h12, 8'hFE, 2'b01, 0, 0);
    run_frame("fb", 8'h80, 8'h7F, 2'b11, 8'h80, 8'h7F, 2'b00, 0, 0);
    chk("period", t0_last - t0_prev, PC);
    run_frame("fc", 8'hC3, 8'h01, 2'b00, 8'hC3, 8'h01, 2'b11, 0, 0);
    chk("period2", t0_last - t0_prev, PC);
    chk("present_on", present, 1);

    run_frame("g_off", 8'h12, 8'hFE, 2'b10, 8'h12, 8'hFE, 2'b01, 0, 1);
    run_frame("g_on", 8'h12, 8'hFE, 2'b10, 8'h52, 8'hFE, 2'b01, 0, 2);

    enable = 1'b0;
    e0 = edge_cnt;
    v0 = vcount;
    repeat (300) @(negedge clk_sys);
    chk("dis_edges", edge_cnt - e0, 0);
    chk("dis_valid", vcount - v0, 0);
    chk("dis_dx_hold", dx, 8'h52);
    enable = 1'b1;

    run_frame("drop", 8'h12, 8'hFE, 2'b10, 8'h12, 8'hFE, 2'b01, 2, 0);
    e0 = edge_cnt;
    repeat (100) @(negedge clk_sys);
    chk("drop_quiet", edge_cnt - e0, 0);
    enable = 1'b1;

    resp_x = 8'h3C;
    resp_y = 8'h3C;
    resp_bp = 2'b11;
    resp_base = edge_cnt;
    wait_t0(ok);
    chk("mid_start", ok, 1);
    repeat (10) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("mid_strobe", strobe, 0);
    chk("mid_dx", dx, 0);
    chk("mid_dy", dy, 0);
    chk("mid_valid", valid, 0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    v0 = vcount;
    run_frame("post", 8'hA5, 8'h3C, 2'b01, 8'hA5, 8'h3C, 2'b10, 0, 0);
    chk("post_vcount", vcount - v0, 1);

`ifdef MSX_MOUSE_DETECT_EN
    for (int i = 0; i < DP; i++) begin
      run_frame("absent", 8'hFF, 8'hFF, 2'b11, (i < DP - 1) ? 8'hFF : 8'h00, (i < DP - 1) ? 8'hFF : 8'h00,
                2'b00, 0, 0);
      chk("absent_present", present, (i < DP - 1) ? 1 : 0);
    end
    run_frame("back", 8'h03, 8'h00, 2'b11, 8'h03, 8'h00, 2'b00, 0, 0);
    chk("back_present", present, 1);
`else
    run_frame("idle_dev", 8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b00, 0, 0);
    chk("idle_present", present, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/msx_mouse_reader.md
Name: msx_mouse_reader

Overview:
- MSX-side initiator for the MSX mouse nibble protocol on a joystick port.
- Toggles the port strobe (pin 8) four times per poll frame and samples four 4-bit nibbles. Assembles signed 8-bit X/Y deltas plus button states.
- Sits between a physical or external-bus joystick port and host logic such as the OSD pointer, PS/2 synthesis or debug readout.
- Counterpart of the core's mouse-to-joystick-port responder.

Parameters:
- SETTLE_CYC, 1000: clk_sys cycles waited after each strobe toggle before sampling the data lines (≈46 us at 21.48 MHz).
- POLL_CYC, 357000: frame period in clk_sys cycles (≈60 Hz). Must exceed 4*(SETTLE_CYC+1)+4.
- DETECT_POLLS, 8: consecutive all-ones frames before the mouse is declared absent (used only by the optional feature).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  polling enable, level
- joy_in  in  6  raw port lines, asynchronous. [3:0] = pins 4..1 (nibble bit3..bit0); [5:4] = buttons 2,1, active-low.
- strobe  out  1  port pin 8 drive
- dx  out  8  signed X delta, raw MSX sense
- dy  out  8  signed Y delta, raw MSX sense
- btn  out  2  buttons, active-high (btn[0]=button 1)
- valid  out  1  one-cycle pulse when dx/dy/btn update
- present  out  1  mouse-present flag

Behaviour:
- Reset values: strobe=0, dx=0, dy=0, btn=0, valid=0, present=1. Internal state: poll_cnt=0, state=IDLE, nibble index=0.
- Reset mid-frame: the frame is abandoned with no valid pulse; the next frame starts at nibble 0.
- Input synchronisation: joy_in passes through a 2-flop synchroniser. All samples use the synchronised value.
- Poll counter:
  - poll_cnt is free-running and wraps from POLL_CYC-1 to 0 regardless of state.
  - A frame starts on the cycle poll_cnt==POLL_CYC-1 if state==IDLE and enable==1.
  - enable is examined only at frame start. Deasserting enable mid-frame lets the frame complete.
- State machine: IDLE -> SETTLE -> SAMPLE -> (SETTLE for nibbles 0..2 | DONE after nibble 3) -> IDLE.
  - Frame start cycle T0: strobe inverts and settle_cnt clears.
  - SETTLE counts SETTLE_CYC cycles.
  - The SAMPLE cycle captures sync[3:0] into nibble[idx]. For idx<3 it inverts strobe again on the same edge and returns to SETTLE.
  - Sample times: T0+k*(SETTLE_CYC+1)+SETTLE_CYC for k=0..3.
- Nibble map: nibble0 = X[7:4], nibble1 = X[3:0], nibble2 = Y[7:4], nibble3 = Y[3:0].
- Buttons: captured as ~sync[5:4] on the nibble-3 sample.
- DONE (one cycle after the last sample):
  - dx, dy and btn register the assembled values; valid=1 for exactly that cycle.
  - The state returns to IDLE on the next cycle.
- Strobe parity: four toggles per frame, so strobe ends each frame at its pre-frame level.
- No arithmetic: the bytes are passed through as two's-complement. Sign convention is the consumer's responsibility.
- With enable=0: strobe holds its level, valid never pulses, and outputs hold their last values.

Optional Feature:
- Macro: MSX_MOUSE_DETECT_EN.
- Defined:
  - A frame with X==8'hFF and Y==8'hFF (idle joystick or no device) increments an absent counter, saturating at DETECT_POLLS.
  - Any other frame clears the counter and sets present=1.
  - On reaching DETECT_POLLS, present=0. While present==0, DONE drives dx=0, dy=0 and btn from the sample, and still pulses valid.
- Undefined: present is tied to 1 and dx/dy always carry the raw bytes.

Test Plan:
- SETTLE_CYC=4, POLL_CYC=64, enable=1, responder model returns X=8'h12, Y=8'hFE, buttons pins=2'b10 -> one valid pulse per 64 cycles with dx=8'h12, dy=8'hFE, btn=2'b01. Exactly 4 strobe edges per frame, 5 cycles apart.
- Strobe timing: first toggle at poll_cnt wrap -> samples at T0+4, +9, +14, +19; valid at T0+20; strobe level after frame equals its level before the frame.
- enable=0 for 300 cycles -> zero strobe edges and no valid pulse. enable deasserted 2 cycles after T0 -> that frame still completes and valid pulses once.
- reset asserted at T0+10 (mid-nibble 2) -> strobe=0, dx=dy=0, no valid. After release, the next frame captures nibble 0 first and decodes correctly.
- MSX_MOUSE_DETECT_EN, DETECT_POLLS=8, joy_in held 6'h3F -> present drops to 0 after the 8th frame with dx=dy=0. A frame with X=8'h03 -> present=1, dx=8'h03.
- Data changing during SETTLE (glitch at T0+2) -> the value at sample time T0+4 is used. A glitch before the 2-flop delay has elapsed is not captured.
